// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit combinational full adder, time-shared by serial_adder_ctrl.
module fullAdder (
    output logic sum,
    output logic carry,
    input  logic op1,
    input  logic op2,
    input  logic op3
);

    assign sum   = op1 ^ op2 ^ op3;
    assign carry = (op1 & op2) | (op1 & op3) | (op2 & op3);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fullAdder walks the operands LSB to MSB, one bit per
// clock, bracketed by a start/busy/done handshake with a held registered result.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output state_t           dbg_state
);

    // Handshake: start is only sampled in IDLE; busy marks SHIFT, done is a
    // one-cycle strobe in DONE; sum/carry are valid from the done cycle onward
    // and hold until the next operation's terminal edge.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             fa_sum;
    logic             fa_carry;

    fullAdder u_fa (
        .sum   (fa_sum),
        .carry (fa_carry),
        .op1   (a_q[0]),
        .op2   (b_q[0]),
        .op3   (cy_q)
    );

    // Result enters at the MSB so after WIDTH shifts bit 0 holds the LSB sum.
    assign res_d = {fa_sum, res_q[WIDTH-1:1]};
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= op1;
                        b_q     <= op2;
                        cy_q    <= cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cy_q  <= fa_carry;
                    res_q <= res_d;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= res_d;
                        carry_q <= fa_carry;
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign dbg_state = state_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-shares one instance of the existing single-bit fullAdder cell across WIDTH-bit operands, processing one bit per clock from LSB to MSB. A start/busy/done handshake brackets each operation, and the result is held stable on registered outputs until the next operation completes. Host logic uses it wherever area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op1  input  WIDTH  operand A; captured on the accepted start edge
op2  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  carry-in; captured on the accepted start edge
busy  output  1  high while an operation is in progress (SHIFT state)
done  output  1  single-cycle completion strobe
sum  output  WIDTH  registered result of the last completed operation
carry  output  1  registered carry-out of the last completed operation

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: busy=0, done=0, sum=0, carry=0, state=IDLE. Internal shift registers, carry flop and bit counter are also cleared.
- FSM states: IDLE, SHIFT, DONE. Encoding is fixed in the shared package.
- IDLE, start=1 at edge k:
  - load A and B shift registers from op1 and op2;
  - carry flop <= cin; counter <= 0; state -> SHIFT.
- IDLE, start=0: remain in IDLE; outputs hold.
- SHIFT, each edge:
  - fullAdder inputs are A[0], B[0] and the carry flop;
  - the sum bit shifts into the MSB of the result shift register, which shifts right;
  - A and B shift right; carry flop <= carry output; counter += 1.
- Terminal SHIFT edge (counter == WIDTH-1, i.e. edge k+WIDTH):
  - sum <= completed result register; carry <= final carry;
  - state -> DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE.
- Latency: start sampled at edge k; busy high from k to k+WIDTH; done high from k+WIDTH to k+WIDTH+1. Total is WIDTH+1 cycles start-to-IDLE.
- busy is decoded from state==SHIFT. done is decoded from state==DONE. Both are glitch-free registered-state decodes.
- start while in SHIFT or DONE is ignored: no queueing and no effect on the operation in flight. Back-to-back operations need start in the IDLE cycle after done.
- op1, op2 and cin may change freely after the capture edge with no effect on the result.
- sum and carry change only at the terminal SHIFT edge or on reset. During SHIFT they still show the previous result.
- Arithmetic: {carry, sum} = op1 + op2 + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no done strobe is produced. After release, the FSM is in IDLE and accepts start on the first edge.
- Counter width: $clog2(WIDTH); it saturates logic at WIDTH-1 and wraps to 0 when reloaded.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default.
- Exactly one sub-module: the existing fullAdder, instantiated once with port order (sum, carry, op1, op2, op3). It is purely combinational. Sequencing, registers and counter stay in serial_adder_ctrl.

Test Plan:
1. WIDTH=8, op1=0x0F, op2=0x01, cin=0, start pulse -> busy for 8 cycles, done 8 cycles after the start edge, sum=0x10, carry=0.
2. op1=0xFF, op2=0x01, cin=0 -> sum=0x00, carry=1; op1=0xFF, op2=0xFF, cin=1 -> sum=0xFF, carry=1.
3. Exhaustive sweep with WIDTH=2 over all 32 (op1, op2, cin) combinations -> {carry, sum} equals op1+op2+cin every time, and exactly one done per start.
4. start held high continuously, and also pulsed at SHIFT cycle 3 -> only the IDLE-sampled start is accepted. Result is unaffected by the mid-operation pulse or by operands changed after capture.
5. Reset asserted at SHIFT cycle 4 of 0xAA+0x55 -> busy, done, sum and carry are 0 asynchronously, with no done pulse. A new 0x01+0x01 after release gives sum=0x02.
6. Back-to-back: start in the IDLE cycle after done -> second result 0x80+0x80 gives sum=0x00, carry=1. The first result is held until the second terminal edge.
